// File: rtl/edge_point_reader.sv
// Raster-scans the contour label BRAM after tracing and streams out the (x,y) of every
// traced-contour pixel, keeping a saturating point count and the contour bounding box.
module edge_point_reader #(
    parameter int         WIDTH        = 640,
    parameter int         HEIGHT       = 480,
    parameter int         READ_LATENCY = 2,
    parameter logic [2:0] MARK_VALUE   = 3'b001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  bram_read,
    output logic [18:0] edge_addr_read,
    output logic [9:0]  point_x,
    output logic [8:0]  point_y,
    output logic        point_valid,
    input  logic        point_ready,
    output logic [11:0] num_points,
    output logic [9:0]  x_min,
    output logic [9:0]  x_max,
    output logic [8:0]  y_min,
    output logic [8:0]  y_max,
    output logic        empty,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CHECK,
        S_EMIT,
        S_DONE
    } state_t;

    localparam logic [18:0] LAST_ADDR = 19'(WIDTH * HEIGHT - 1);
    localparam logic [9:0]  X_LAST    = 10'(WIDTH - 1);
    localparam logic [2:0]  LAT_LAST  = 3'(READ_LATENCY - 1);
    localparam logic [11:0] NUM_MAX   = 12'd4095;

    state_t      state_r;
    logic [18:0] addr_r;
    logic [9:0]  x_r;
    logic [8:0]  y_r;
    logic [2:0]  lat_cnt_r;

    logic [18:0] addr_next_s;
    logic [9:0]  x_next_s;
    logic [8:0]  y_next_s;
    logic        last_pix_s;
    logic        is_mark_s;

    function automatic logic [11:0] sat_inc(input logic [11:0] v);
        if (v == NUM_MAX) begin
            return v;
        end else begin
            return v + 12'd1;
        end
    endfunction

    // Next raster position and classification of the pixel currently on the read port
    always_comb begin
        last_pix_s  = (addr_r == LAST_ADDR);
        is_mark_s   = (bram_read == MARK_VALUE);
        addr_next_s = addr_r + 19'd1;
        x_next_s    = x_r;
        y_next_s    = y_r;
        if (x_r == X_LAST) begin
            x_next_s = 10'd0;
            y_next_s = y_r + 9'd1;
        end else begin
            x_next_s = x_r + 10'd1;
            y_next_s = y_r;
        end
    end

    // Scan controller: address issue, read-latency wait, pixel check, point handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= S_IDLE;
            addr_r         <= 19'd0;
            x_r            <= 10'd0;
            y_r            <= 9'd0;
            lat_cnt_r      <= 3'd0;
            edge_addr_read <= 19'd0;
            point_x        <= 10'd0;
            point_y        <= 9'd0;
            point_valid    <= 1'b0;
            num_points     <= 12'd0;
            x_min          <= 10'd1023;
            x_max          <= 10'd0;
            y_min          <= 9'd511;
            y_max          <= 9'd0;
            empty          <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        addr_r     <= 19'd0;
                        x_r        <= 10'd0;
                        y_r        <= 9'd0;
                        num_points <= 12'd0;
                        x_min      <= 10'd1023;
                        x_max      <= 10'd0;
                        y_min      <= 9'd511;
                        y_max      <= 9'd0;
                        done       <= 1'b0;
                        empty      <= 1'b0;
                        busy       <= 1'b1;
                        state_r    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    edge_addr_read <= addr_r;
                    lat_cnt_r      <= 3'd0;
                    state_r        <= S_WAIT;
                end
                S_WAIT: begin
                    if (lat_cnt_r == LAT_LAST) begin
                        state_r <= S_CHECK;
                    end else begin
                        lat_cnt_r <= lat_cnt_r + 3'd1;
                    end
                end
                S_CHECK: begin
                    if (is_mark_s) begin
                        point_x     <= x_r;
                        point_y     <= y_r;
                        point_valid <= 1'b1;
                        num_points  <= sat_inc(num_points);
                        if (x_r < x_min) x_min <= x_r;
                        if (x_r > x_max) x_max <= x_r;
                        if (y_r < y_min) y_min <= y_r;
                        if (y_r > y_max) y_max <= y_r;
                        state_r     <= S_EMIT;
                    end else if (last_pix_s) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        empty   <= (num_points == 12'd0);
                        state_r <= S_DONE;
                    end else begin
                        addr_r  <= addr_next_s;
                        x_r     <= x_next_s;
                        y_r     <= y_next_s;
                        state_r <= S_ISSUE;
                    end
                end
                S_EMIT: begin
                    // Hold the point until the downstream takes it, then resume the scan
                    if (point_ready) begin
                        point_valid <= 1'b0;
                        if (last_pix_s) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            empty   <= (num_points == 12'd0);
                            state_r <= S_DONE;
                        end else begin
                            addr_r  <= addr_next_s;
                            x_r     <= x_next_s;
                            y_r     <= y_next_s;
                            state_r <= S_ISSUE;
                        end
                    end
                end
                default: begin
                    state_r     <= S_IDLE;
                    point_valid <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule
